// File: rtl/funcao_2_mux.sv
// Three-variable function cell: a 4:1 mux picks D[{A,B}] and XORs it with C.
// Also registers the result and its index, and accumulates a truth table of every index seen since reset.
module funcao_2_mux (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D0,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    output logic       Y,
    output logic       Y_q,
    output logic [2:0] idx_q,
    output logic [7:0] tt,
    output logic [7:0] tt_seen,
    output logic       tt_done
);

    logic [1:0] sel;
    logic [3:0] d_vec;
    logic       y_comb;

    logic       y_reg_d;
    logic       y_reg_q;
    logic [2:0] idx_d;
    logic [2:0] idx_reg_q;
    logic [7:0] tt_d;
    logic [7:0] tt_q;
    logic [7:0] tt_seen_d;
    logic [7:0] tt_seen_q;

    // Combinational function path: no dependence on clk or rst.
    always_comb begin
        sel    = {A, B};
        d_vec  = {D3, D2, D1, D0};
        y_comb = d_vec[sel] ^ C;
    end

    // Next-state: capture the current Y at index {A,B,C}; all other table bits hold.
    always_comb begin
        y_reg_d          = y_comb;
        idx_d            = {A, B, C};
        tt_d             = tt_q;
        tt_d[idx_d]      = y_comb;
        tt_seen_d        = tt_seen_q;
        tt_seen_d[idx_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg_q   <= 1'b0;
            idx_reg_q <= 3'b000;
            tt_q      <= 8'h00;
            tt_seen_q <= 8'h00;
        end else begin
            y_reg_q   <= y_reg_d;
            idx_reg_q <= idx_d;
            tt_q      <= tt_d;
            tt_seen_q <= tt_seen_d;
        end
    end

    assign Y       = y_comb;
    assign Y_q     = y_reg_q;
    assign idx_q   = idx_reg_q;
    assign tt      = tt_q;
    assign tt_seen = tt_seen_q;
    assign tt_done = &tt_seen_q;

endmodule

// File: tb/tb_funcao_2_mux.sv
// Self-checking bench for funcao_2_mux: directed sweeps plus random stimulus,
// all compared against a truth-table model computed from the function's arithmetic definition.
module tb_funcao_2_mux;

    logic       clk;
    logic       rst;
    logic       A, B, C;
    logic       D0, D1, D2, D3;
    logic       Y;
    logic       Y_q;
    logic [2:0] idx_q;
    logic [7:0] tt;
    logic [7:0] tt_seen;
    logic       tt_done;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_yq;
    int m_idx;
    int m_tt[8];
    int m_seen[8];

    funcao_2_mux dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .C       (C),
        .D0      (D0),
        .D1      (D1),
        .D2      (D2),
        .D3      (D3),
        .Y       (Y),
        .Y_q     (Y_q),
        .idx_q   (idx_q),
        .tt      (tt),
        .tt_seen (tt_seen),
        .tt_done (tt_done)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_y(input int n, input int d);
        int k;
        k = n / 2;
        return ((d >> k) % 2) ^ (n % 2);
    endfunction

    function automatic int model_vec(input int which);
        int v;
        v = 0;
        for (int i = 0; i < 8; i++)
            v += (which == 0 ? m_tt[i] : m_seen[i]) << i;
        return v;
    endfunction

    task automatic model_reset();
        m_yq  = 0;
        m_idx = 0;
        for (int i = 0; i < 8; i++) begin
            m_tt[i]   = 0;
            m_seen[i] = 0;
        end
    endtask

    task automatic check_regs(input string tag);
        check_val({tag, ".Y_q"},     int'(Y_q),     m_yq);
        check_val({tag, ".idx_q"},   int'(idx_q),   m_idx);
        check_val({tag, ".tt"},      int'(tt),      model_vec(0));
        check_val({tag, ".tt_seen"}, int'(tt_seen), model_vec(1));
        check_val({tag, ".tt_done"}, int'(tt_done), (model_vec(1) == 255) ? 1 : 0);
    endtask

    // driver: apply index n, data nibble d (bit k = Dk) and reset r for one cycle
    task automatic step(input string tag, input int n, input int d, input int r);
        int y_exp;
        @(negedge clk);
        {A, B, C}          = 3'(n);
        {D3, D2, D1, D0}   = 4'(d);
        rst                = r[0];
        #1;
        y_exp = model_y(n, d);
        check_val({tag, ".Y"}, int'(Y), y_exp);
        @(posedge clk);
        #1;
        if (r != 0) begin
            model_reset();
        end else begin
            m_yq       = y_exp;
            m_idx      = n;
            m_tt[n]    = y_exp;
            m_seen[n]  = 1;
        end
        check_regs(tag);
    endtask

    initial begin
        int d;
        int n;
        {A, B, C}        = 3'b000;
        {D3, D2, D1, D0} = 4'b0000;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");

        // parity sweep: D0..D3 = 0,1,1,0
        for (int i = 0; i < 8; i++) step("parity", i, 4'b0110, 0);
        check_val("parity.tt_const", int'(tt), 8'h96);
        check_val("parity.done_const", int'(tt_done), 1);

        // D0..D3 = 1,0,0,0 sweep after reset
        step("rst1", 0, 0, 1);
        for (int i = 0; i < 8; i++) step("d1000", i, 4'b0001, 0);
        check_val("d1000.tt_const", int'(tt), 8'hA9);

        // reset mid-sweep after four capture edges
        step("rst2", 0, 0, 1);
        for (int i = 0; i < 4; i++) step("half", i, 4'b0110, 0);
        step("midrst", 5, 4'b0110, 1);
        check_val("midrst.tt_seen_const", int'(tt_seen), 0);
        for (int i = 7; i >= 1; i--) step("resume", i, 4'b0110, 0);
        check_val("resume.not_done", int'(tt_done), 0);
        step("resume", 0, 4'b0110, 0);
        check_val("resume.done", int'(tt_done), 1);

        // hold index 2 while D1 toggles 1 -> 0
        step("rst3", 0, 0, 1);
        step("hold", 2, 4'b0010, 0);
        step("hold", 2, 4'b0010, 0);
        step("hold", 2, 4'b0000, 0);
        step("hold", 2, 4'b0000, 0);
        check_val("hold.tt_seen_const", int'(tt_seen), 8'h04);

        // D all ones, C toggles with A=B=0
        for (int i = 0; i < 6; i++) step("ctog", i % 2, 4'b1111, 0);

        // reset held while inputs sweep
        for (int i = 0; i < 8; i++) step("rsthold", i, 4'b1010, 1);

        // random stimulus with occasional reset
        for (int i = 0; i < 300; i++) begin
            n = int'($urandom_range(0, 7));
            d = int'($urandom_range(0, 15));
            step("rand", n, d, ($urandom_range(0, 19) == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
